// File: rtl/hex_line_formatter.sv
// Formats one captured sample per line as uppercase ASCII hex plus a line terminator over a valid/ready byte stream.
// Optional "0x" line prefix is enabled by defining the macro HEX_PREFIX_EN.

module hex_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Map 0-9 onto '0'-'9' and 10-15 onto 'A'-'F'.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

module hex_line_formatter #(
    parameter int DATA_WIDTH = 16,
    parameter int EOL_CRLF   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

`ifdef HEX_PREFIX_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, HEX = 3'd1, CR = 3'd2, LF = 3'd3, P0 = 3'd4, P1 = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, HEX = 3'd1, CR = 3'd2, LF = 3'd3
    } state_t;
`endif

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        index_r, index_s;
    logic [DATA_WIDTH-1:0]   capture_r, capture_s;
    logic                    ready_r;
    logic                    valid_r;
    logic                    accept_s;
    logic                    xfer_s;
    logic [DATA_WIDTH-1:0]   shifted_s;
    logic [3:0]              nibble_s;
    logic [7:0]              ascii_s;
    logic [7:0]              tx_data_s;

    assign accept_s = i_valid & ready_r;
    assign xfer_s   = valid_r & i_tx_ready;

    // Next-state, nibble index and capture logic; everything advances only on a byte transfer.
    always_comb begin
        state_s   = state_r;
        index_s   = index_r;
        capture_s = capture_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    capture_s = i_data;
                    index_s   = IDX_TOP;
`ifdef HEX_PREFIX_EN
                    state_s   = P0;
`else
                    state_s   = HEX;
`endif
                end else begin
                    state_s   = IDLE;
                end
            end
`ifdef HEX_PREFIX_EN
            P0: begin
                if (xfer_s) begin
                    state_s = P1;
                end else begin
                    state_s = P0;
                end
            end
            P1: begin
                if (xfer_s) begin
                    state_s = HEX;
                end else begin
                    state_s = P1;
                end
            end
`endif
            HEX: begin
                if (xfer_s) begin
                    if (index_r != {IDX_W{1'b0}}) begin
                        index_s = index_r - IDX_W'(1'b1);
                    end else begin
                        state_s = (EOL_CRLF != 0) ? CR : LF;
                    end
                end else begin
                    state_s = HEX;
                end
            end
            CR: begin
                if (xfer_s) begin
                    state_s = LF;
                end else begin
                    state_s = CR;
                end
            end
            LF: begin
                if (xfer_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = LF;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, capture and handshake flags; reset is asynchronous so a line can be abandoned instantly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= IDLE;
            index_r   <= {IDX_W{1'b0}};
            capture_r <= {DATA_WIDTH{1'b0}};
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            capture_r <= capture_s;
            ready_r   <= (state_s == IDLE);
            valid_r   <= (state_s != IDLE);
        end
    end

    // The outgoing byte is a pure decode of registered state, so it cannot move during back-pressure.
    assign shifted_s = capture_r >> {index_r, 2'b00};
    assign nibble_s  = shifted_s[3:0];

    hex_to_ascii u_hex_to_ascii (
        .nibble (nibble_s),
        .ascii  (ascii_s)
    );

    // Byte selection per line position.
    always_comb begin
        tx_data_s = 8'h00;
        case (state_r)
            HEX:     tx_data_s = ascii_s;
            CR:      tx_data_s = 8'h0D;
            LF:      tx_data_s = 8'h0A;
`ifdef HEX_PREFIX_EN
            P0:      tx_data_s = 8'h30;
            P1:      tx_data_s = 8'h78;
`endif
            default: tx_data_s = 8'h00;
        endcase
    end

    assign o_tx_data  = tx_data_s;
    assign o_tx_valid = valid_r;
    assign o_ready    = ready_r;
    assign o_busy     = ~ready_r;

endmodule

// File: tb/tb_hex_line_formatter.sv
// Directed bench for hex_line_formatter: vector table plus hand-written reset, back-to-back and busy sequences.
`timescale 1ns/1ps

module tb_hex_line_formatter;

`ifdef HEX_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;

    logic [11:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  b_tx_data;
    logic        b_tx_valid;
    logic        b_tx_ready;
    logic        b_busy;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] q[$];
    logic [7:0] qb[$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    hex_line_formatter #(.DATA_WIDTH(16), .EOL_CRLF(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready), .o_busy(o_busy)
    );

    hex_line_formatter #(.DATA_WIDTH(12), .EOL_CRLF(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready), .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid),
        .i_tx_ready(b_tx_ready), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] exp, input int len, input int i);
        if (i < PFX) return (i == 0) ? 8'h30 : 8'h78;
        return exp[8*(len-1-(i-PFX)) +: 8];
    endfunction

    // Byte collector and stall-stability checker, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(o_tx_valid), 32'd1);
                check("stall_data", 32'(o_tx_data), 32'(stall_data));
            end
            if (o_tx_valid && i_tx_ready) q.push_back(o_tx_data);
            stall_prev = o_tx_valid && !i_tx_ready;
            stall_data = o_tx_data;
        end
    end

    task automatic compare_q(input string name, input logic [63:0] exp, input int len);
        check({name, "_len"}, 32'(q.size()), 32'(len + PFX));
        for (int i = 0; i < len + PFX && i < q.size(); i++)
            check({name, "_byte"}, 32'(q[i]), 32'(exp_byte(exp, len, i)));
    endtask

    task automatic run_vec(input string name, input logic [15:0] d, input logic [3:0] pat,
                           input logic [63:0] exp, input int len);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin @(negedge clk); n++; end
        check({name, "_ready"}, 32'(o_ready), 32'd1);
        q.delete();
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_data  = 16'($urandom);
        n = 0;
        while (q.size() < len + PFX && n < 100) begin
            i_tx_ready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        i_tx_ready = 1'b1;
        compare_q(name, exp, len);
        @(negedge clk);
        check({name, "_idle_ready"}, 32'(o_ready), 32'd1);
        check({name, "_idle_valid"}, 32'(o_tx_valid), 32'd0);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  pat;
        logic [63:0] exp;
        int          len;
    } vec_t;

    vec_t vecs[5];
    int   low_cnt;

    initial begin
        vecs[0] = '{16'hBEEF, 4'b1111, 64'h0000_4245_4546_0D0A, 6};
        vecs[1] = '{16'h0A5F, 4'b1001, 64'h0000_3041_3546_0D0A, 6};
        vecs[2] = '{16'h0000, 4'b0101, 64'h0000_3030_3030_0D0A, 6};
        vecs[3] = '{16'hFFFF, 4'b1110, 64'h0000_4646_4646_0D0A, 6};
        vecs[4] = '{16'h1234, 4'b0011, 64'h0000_3132_3334_0D0A, 6};

        rst = 1'b1; i_data = 16'h0; i_valid = 1'b0; i_tx_ready = 1'b1;
        b_data = 12'h0; b_valid = 1'b0; b_tx_ready = 1'b1;
        #3;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_tx_valid), 32'd0);
        check("rst_data", 32'(o_tx_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: BEEF with exact per-cycle timing.
        q.delete();
        @(negedge clk);
        i_valid = 1'b1; i_data = 16'hBEEF;
        @(posedge clk); #1;
        i_valid = 1'b0; i_data = 16'h5555;
        for (int c = 0; c < 6 + PFX; c++) begin
            @(negedge clk);
            check("t1_ready_low", 32'(o_ready), 32'd0);
            check("t1_busy", 32'(o_busy), 32'd1);
            check("t1_valid", 32'(o_tx_valid), 32'd1);
            check("t1_byte", 32'(o_tx_data), 32'(exp_byte(64'h0000_4245_4546_0D0A, 6, c)));
        end
        @(negedge clk);
        check("t1_ready_back", 32'(o_ready), 32'd1);
        check("t1_valid_off", 32'(o_tx_valid), 32'd0);

        // Table vectors with assorted back-pressure patterns.
        for (int v = 0; v < 5; v++)
            run_vec($sformatf("vec%0d", v), vecs[v].data, vecs[v].pat, vecs[v].exp, vecs[v].len);

        // Test 3: back-to-back lines with i_valid held.
        q.delete();
        @(negedge clk);
        i_valid = 1'b1; i_data = 16'h1234;
        @(posedge clk); #1;
        i_data = 16'hFFFF;
        low_cnt = 0;
        @(negedge clk);
        while (!o_ready && low_cnt < 30) begin low_cnt++; @(negedge clk); end
        check("t3_low_cycles", 32'(low_cnt), 32'(6 + PFX));
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (6 + PFX) @(posedge clk);
        #1;
        check("t3_len", 32'(q.size()), 32'(12 + 2*PFX));
        for (int i = 0; i < 6 + PFX && i + 6 + PFX < q.size(); i++) begin
            check("t3_first", 32'(q[i]), 32'(exp_byte(64'h0000_3132_3334_0D0A, 6, i)));
            check("t3_second", 32'(q[i+6+PFX]), 32'(exp_byte(64'h0000_4646_4646_0D0A, 6, i)));
        end

        // Test 4: a pulse while busy must not be captured.
        q.delete();
        @(negedge clk);
        i_valid = 1'b1; i_data = 16'h0000;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b1; i_data = 16'h9999;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        compare_q("t4", 64'h0000_3030_3030_0D0A, 6);
        check("t4_idle", 32'(o_ready), 32'd1);

        // Test 5: asynchronous reset mid-line.
        q.delete();
        @(negedge clk);
        i_valid = 1'b1; i_data = 16'hC0DE;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2 + PFX) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_valid", 32'(o_tx_valid), 32'd0);
        check("t5_ready", 32'(o_ready), 32'd1);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_partial", 32'(q.size()), 32'(2 + PFX));
        if (q.size() >= 2 + PFX) begin
            check("t5_b0", 32'(q[PFX]), 32'h43);
            check("t5_b1", 32'(q[PFX+1]), 32'h30);
        end
        @(posedge clk); #1 rst = 1'b0;
        run_vec("t5_after", 16'h0001, 4'b1111, 64'h0000_3030_3031_0D0A, 6);

        // Test 6: 12-bit instance with LF-only terminator.
        qb.delete();
        @(negedge clk);
        b_valid = 1'b1; b_data = 12'hABC;
        @(posedge clk); #1;
        b_valid = 1'b0;
        for (int c = 0; c < 20 && qb.size() < 4 + PFX; c++) begin
            @(negedge clk);
            if (b_tx_valid && b_tx_ready) qb.push_back(b_tx_data);
        end
        check("t6_len", 32'(qb.size()), 32'(4 + PFX));
        for (int i = 0; i < 4 + PFX && i < qb.size(); i++)
            check("t6_byte", 32'(qb[i]), 32'(exp_byte(64'h0000_0000_4142_430A, 4, i)));
        @(negedge clk);
        check("t6_idle", 32'(b_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
